aib_link_init_seq: RTL and testbench
====================================

AIB_LINK_INIT_SEQ -- requirements
Module: aib_link_init_seq

Interface
REQ-001 SHALL have parameter ACTIVE_CHNLS, default 1: number of low-order channels sequenced.
REQ-002 SHALL have parameter NBR_CHNLS, default 24: channel vector width.
REQ-003 SHALL have parameter AVMM_WIDTH, default 32, and BYTE_WIDTH, default 4: AVMM data and byte-enable widths.
REQ-004 SHALL have parameter NUM_CFG, default 8: number of config table entries.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 4096: timeout limit in cycles.
REQ-006 SHALL have one clock and an asynchronous, active-low reset: avmm_clk  in  1  sole clock; avmm_rst_n  in  1  async active-low reset.
REQ-007 start  in  1  single-cycle pulse that begins or restarts bring-up.
REQ-008 o_cfg_avmm_addr  out  17  AVMM address.
REQ-009 o_cfg_avmm_byte_en  out  BYTE_WIDTH  AVMM byte enable.
REQ-010 o_cfg_avmm_read / o_cfg_avmm_write  out  1 each  AVMM commands.
REQ-011 o_cfg_avmm_wdata  out  AVMM_WIDTH  AVMM write data.
REQ-012 i_cfg_avmm_rdata  in  AVMM_WIDTH  AVMM read data.
REQ-013 i_cfg_avmm_rdatavld  in  1  read data valid.
REQ-014 i_cfg_avmm_waitreq  in  1  AVMM stall.
REQ-015 ns_adapter_rstn  out  NBR_CHNLS  per-channel adapter reset release.
REQ-016 ns_mac_rdy  out  NBR_CHNLS  near-side MAC ready.
REQ-017 fs_mac_rdy  in  NBR_CHNLS  far-side MAC ready.
REQ-018 m_rx_align_done  in  NBR_CHNLS  per-channel RX alignment done.
REQ-019 link_up  out  1  link operational.
REQ-020 busy  out  1  sequence in progress.
REQ-021 error  out  1  sequence failed.
REQ-022 err_code  out  2  failure cause: 01 = readback mismatch, 10 = AVMM timeout, 11 = align timeout or link lost.

Function
REQ-023 The FSM SHALL have states IDLE, WR, RD, RD_WAIT, RST_REL, MAC_RDY, WAIT_ALIGN, LINK_UP and ERROR.
REQ-024 In IDLE or ERROR, start SHALL clear error and err_code, set the table index to 0 and enter WR on the next cycle.
REQ-025 start SHALL be ignored in all other states.
REQ-026 WR SHALL drive write=1, addr=CFG_ADDR[idx], wdata=CFG_DATA[idx] and byte_en all-ones, holding them while waitreq=1.
REQ-027 A write SHALL be accepted in the first cycle with waitreq=0; the FSM SHALL then enter RD.
REQ-028 RD SHALL drive read=1 at the same address, held while waitreq=1; on acceptance it SHALL enter RD_WAIT with read=0.
REQ-029 In RD_WAIT, on rdatavld: if (rdata & CFG_MASK[idx]) == (CFG_DATA[idx] & CFG_MASK[idx]), the index SHALL increment and the FSM SHALL enter WR, or RST_REL if idx == NUM_CFG-1.
REQ-030 In RD_WAIT, on rdatavld with a mismatch, the FSM SHALL enter ERROR with err_code=01.
REQ-031 The timeout counter SHALL reset on entry to WR, RD, RD_WAIT and WAIT_ALIGN.
REQ-032 Reaching TIMEOUT_CYC in WR, RD or RD_WAIT SHALL enter ERROR with err_code=10.
REQ-033 RST_REL SHALL set ns_adapter_rstn[ACTIVE_CHNLS-1:0]=1 (held thereafter until ERROR or reset) and enter MAC_RDY after 1 cycle.
REQ-034 MAC_RDY SHALL set ns_mac_rdy[ACTIVE_CHNLS-1:0]=1 and enter WAIT_ALIGN after 1 cycle.
REQ-035 WAIT_ALIGN SHALL enter LINK_UP when all active bits of fs_mac_rdy and m_rx_align_done are 1.
REQ-036 WAIT_ALIGN SHALL enter ERROR with err_code=11 when the timeout counter reaches TIMEOUT_CYC.
REQ-037 If the completion condition and the timeout occur in the same cycle, completion SHALL win.
REQ-038 LINK_UP SHALL drive link_up=1 (registered, asserted the cycle after the align condition is seen).
REQ-039 Any active bit of fs_mac_rdy or m_rx_align_done falling while in LINK_UP SHALL enter ERROR with err_code=11.
REQ-040 ERROR SHALL drive error=1, deassert ns_adapter_rstn, ns_mac_rdy and link_up, and drive AVMM commands to 0.
REQ-041 Bits [NBR_CHNLS-1:ACTIVE_CHNLS] of ns_adapter_rstn and ns_mac_rdy SHALL always be 0.
REQ-042 busy SHALL be 1 in WR through WAIT_ALIGN and 0 otherwise.
REQ-043 An AVMM command SHALL never be withdrawn while waitreq=1.

Reset
REQ-044 avmm_rst_n=0 SHALL asynchronously force state IDLE, idx 0, counter 0 and all outputs to 0, including ns_adapter_rstn and ns_mac_rdy.
REQ-045 Reset asserted mid-transfer SHALL abandon the transfer with no completion.
REQ-046 Reset SHALL be released synchronously to avmm_clk.

Structure
REQ-047 Package aib_init_pkg SHALL hold the state enum, err_code constants, and the CFG_ADDR, CFG_DATA and CFG_MASK arrays (entry 0: addr 17'h00208, data 32'h0000_0001, mask 32'hFFFF_FFFF).
REQ-048 One sub-module, aib_init_timeout (a loadable saturating counter with an expired flag), SHALL be used; the FSM and datapath SHALL stay in one module.

Verification
REQ-049 start with waitreq=0 and an ideal AVMM model echoing writes, then all active align/mac bits driven 1 at cycle 100 -> 8 writes and 8 reads in table order, link_up=1 at cycle 101, error=0.
REQ-050 waitreq held 1 for 5 cycles on entry 0 write -> write/addr/wdata stable for all 5 cycles, exactly one write accepted.
REQ-051 Readback of entry 3 returns 32'h0 -> ERROR, err_code=01, ns_adapter_rstn=0; a second start restarts at addr 17'h00208.
REQ-052 rdatavld never asserted (TIMEOUT_CYC=16) -> ERROR with err_code=10 exactly 16 cycles after RD_WAIT entry.
REQ-053 In LINK_UP, drop m_rx_align_done[0] -> next cycle error=1, err_code=11, link_up=0.
REQ-054 avmm_rst_n pulsed low during RD -> all outputs 0 immediately, state IDLE, no spurious AVMM command after release.

Source files
------------

// File: rtl/aib_init_pkg.sv
// Shared definitions for the AIB link bring-up sequencer.
//   state_e      : sequencer FSM states
//   ERR_*        : err_code values reported on failure
//   CFG_ADDR/DATA/MASK : configuration table written, then read back and
//                  compared under mask, before the channels are released.
package aib_init_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WR,
        RD,
        RD_WAIT,
        RST_REL,
        MAC_RDY,
        WAIT_ALIGN,
        LINK_UP,
        ERROR
    } state_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISMATCH = 2'b01;
    localparam logic [1:0] ERR_AVMM_TO  = 2'b10;
    localparam logic [1:0] ERR_LINK     = 2'b11;

    localparam int CFG_ENTRIES = 8;

    localparam logic [16:0] CFG_ADDR [CFG_ENTRIES] = '{
        17'h00208, 17'h0020C, 17'h00210, 17'h00214,
        17'h00300, 17'h00304, 17'h0031C, 17'h00320
    };

    localparam logic [31:0] CFG_DATA [CFG_ENTRIES] = '{
        32'h0000_0001, 32'h0000_00A5, 32'h8000_0003, 32'h0001_0F00,
        32'h1234_5678, 32'h0000_0040, 32'h0A0B_0C0D, 32'h0000_0007
    };

    // Only masked bits are compared on readback; the rest may be
    // status/reserved bits that legitimately read back differently.
    localparam logic [31:0] CFG_MASK [CFG_ENTRIES] = '{
        32'hFFFF_FFFF, 32'h0000_00FF, 32'h8000_000F, 32'h0001_FF00,
        32'hFFFF_FFFF, 32'h0000_00C0, 32'h0F0F_0F0F, 32'h0000_0007
    };

endpackage

// File: rtl/aib_init_timeout.sv
// Saturating cycle counter used to bound every wait in the sequencer.
//   clk, rst_n : clock, async active-low reset
//   clr        : restart counting from zero (asserted on state entry)
//   expired    : high during the LIMIT-th cycle after clr, and stays high
module aib_init_timeout #(
    parameter int LIMIT = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic expired
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt;

    // cnt holds the number of completed cycles since clr, so the cycle in
    // which cnt == LIMIT-1 is the LIMIT-th cycle spent waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (!expired)
            cnt <= cnt + CW'(1);
    end

    assign expired = (cnt >= LAST);

endmodule

// File: rtl/aib_link_init_seq.sv
// AIB link bring-up sequencer.
// Writes each configuration table entry over AVMM, reads it back and checks
// it under mask, then releases the adapter resets, raises near-side MAC
// ready and waits for far-side ready plus RX alignment on all active
// channels. Any failure parks the FSM in ERROR until the next start.
//   avmm_clk, avmm_rst_n     : clock, async active-low reset
//   start                    : begin/restart bring-up (IDLE or ERROR only)
//   o_cfg_avmm_*             : AVMM master (addr, byte_en, read, write, wdata)
//   i_cfg_avmm_*             : AVMM rdata, rdatavld, waitreq
//   ns_adapter_rstn, ns_mac_rdy : per-channel controls (active channels only)
//   fs_mac_rdy, m_rx_align_done : per-channel status from the link
//   link_up, busy, error, err_code : sequence status
module aib_link_init_seq
    import aib_init_pkg::*;
#(
    parameter int ACTIVE_CHNLS = 1,
    parameter int NBR_CHNLS    = 24,
    parameter int AVMM_WIDTH   = 32,
    parameter int BYTE_WIDTH   = 4,
    parameter int NUM_CFG      = 8,
    parameter int TIMEOUT_CYC  = 4096
) (
    input  logic                  avmm_clk,
    input  logic                  avmm_rst_n,
    input  logic                  start,
    output logic [16:0]           o_cfg_avmm_addr,
    output logic [BYTE_WIDTH-1:0] o_cfg_avmm_byte_en,
    output logic                  o_cfg_avmm_read,
    output logic                  o_cfg_avmm_write,
    output logic [AVMM_WIDTH-1:0] o_cfg_avmm_wdata,
    input  logic [AVMM_WIDTH-1:0] i_cfg_avmm_rdata,
    input  logic                  i_cfg_avmm_rdatavld,
    input  logic                  i_cfg_avmm_waitreq,
    output logic [NBR_CHNLS-1:0]  ns_adapter_rstn,
    output logic [NBR_CHNLS-1:0]  ns_mac_rdy,
    input  logic [NBR_CHNLS-1:0]  fs_mac_rdy,
    input  logic [NBR_CHNLS-1:0]  m_rx_align_done,
    output logic                  link_up,
    output logic                  busy,
    output logic                  error,
    output logic [1:0]            err_code
);

    localparam int IDX_W = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CFG - 1);
    // Low ACTIVE_CHNLS bits set; inactive channels are never driven.
    localparam logic [NBR_CHNLS-1:0] ACT_MASK =
        NBR_CHNLS'((64'd1 << ACTIVE_CHNLS) - 64'd1);

    state_e           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [1:0]       err_q, err_nxt;
    logic             to_clr, to_expired;
    logic             align_ok, rd_match;

    logic [AVMM_WIDTH-1:0] cfg_data, cfg_mask;

    assign cfg_data = AVMM_WIDTH'(CFG_DATA[idx]);
    assign cfg_mask = AVMM_WIDTH'(CFG_MASK[idx]);
    assign rd_match = ((i_cfg_avmm_rdata & cfg_mask) == (cfg_data & cfg_mask));
    assign align_ok = ((fs_mac_rdy & m_rx_align_done & ACT_MASK) == ACT_MASK);

    aib_init_timeout #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (avmm_clk),
        .rst_n   (avmm_rst_n),
        .clr     (to_clr),
        .expired (to_expired)
    );

    always_ff @(posedge avmm_clk or negedge avmm_rst_n) begin
        if (!avmm_rst_n) begin
            state <= IDLE;
            idx   <= '0;
            err_q <= ERR_NONE;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            err_q <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        err_nxt   = err_q;
        case (state)
            IDLE, ERROR: begin
                if (start) begin
                    state_nxt = WR;
                    idx_nxt   = '0;
                    err_nxt   = ERR_NONE;
                end
            end
            // Acceptance is checked before the timeout so a command granted
            // on the last allowed cycle still completes.
            WR: begin
                if (!i_cfg_avmm_waitreq) begin
                    state_nxt = RD;
                end else if (to_expired) begin
                    state_nxt = ERROR;
                    err_nxt   = ERR_AVMM_TO;
                end
            end
            RD: begin
                if (!i_cfg_avmm_waitreq) begin
                    state_nxt = RD_WAIT;
                end else if (to_expired) begin
                    state_nxt = ERROR;
                    err_nxt   = ERR_AVMM_TO;
                end
            end
            RD_WAIT: begin
                if (i_cfg_avmm_rdatavld) begin
                    if (!rd_match) begin
                        state_nxt = ERROR;
                        err_nxt   = ERR_MISMATCH;
                    end else if (idx == IDX_LAST) begin
                        state_nxt = RST_REL;
                    end else begin
                        state_nxt = WR;
                        idx_nxt   = idx + IDX_W'(1);
                    end
                end else if (to_expired) begin
                    state_nxt = ERROR;
                    err_nxt   = ERR_AVMM_TO;
                end
            end
            RST_REL: state_nxt = MAC_RDY;
            MAC_RDY: state_nxt = WAIT_ALIGN;
            WAIT_ALIGN: begin
                if (align_ok) begin
                    state_nxt = LINK_UP;
                end else if (to_expired) begin
                    state_nxt = ERROR;
                    err_nxt   = ERR_LINK;
                end
            end
            LINK_UP: begin
                if (!align_ok) begin
                    state_nxt = ERROR;
                    err_nxt   = ERR_LINK;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Restart the timeout on entry to any state that waits on the outside.
    always_comb begin
        to_clr = 1'b0;
        if (state_nxt != state) begin
            case (state_nxt)
                WR, RD, RD_WAIT, WAIT_ALIGN: to_clr = 1'b1;
                default:                     to_clr = 1'b0;
            endcase
        end
    end

    // Outputs decode directly from registered state, so reset clears them
    // immediately and a command stays up until the state actually moves on.
    always_comb begin
        o_cfg_avmm_addr    = '0;
        o_cfg_avmm_byte_en = '0;
        o_cfg_avmm_read    = 1'b0;
        o_cfg_avmm_write   = 1'b0;
        o_cfg_avmm_wdata   = '0;
        ns_adapter_rstn    = '0;
        ns_mac_rdy         = '0;
        link_up            = 1'b0;
        busy               = 1'b0;
        error              = 1'b0;
        case (state)
            WR: begin
                o_cfg_avmm_write   = 1'b1;
                o_cfg_avmm_addr    = CFG_ADDR[idx];
                o_cfg_avmm_wdata   = cfg_data;
                o_cfg_avmm_byte_en = '1;
                busy               = 1'b1;
            end
            RD: begin
                o_cfg_avmm_read    = 1'b1;
                o_cfg_avmm_addr    = CFG_ADDR[idx];
                o_cfg_avmm_byte_en = '1;
                busy               = 1'b1;
            end
            RD_WAIT: busy = 1'b1;
            RST_REL: begin
                ns_adapter_rstn = ACT_MASK;
                busy            = 1'b1;
            end
            MAC_RDY, WAIT_ALIGN: begin
                ns_adapter_rstn = ACT_MASK;
                ns_mac_rdy      = ACT_MASK;
                busy            = 1'b1;
            end
            LINK_UP: begin
                ns_adapter_rstn = ACT_MASK;
                ns_mac_rdy      = ACT_MASK;
                link_up         = 1'b1;
            end
            ERROR:   error = 1'b1;
            default: ;
        endcase
    end

    assign err_code = err_q;

endmodule

// File: tb/tb_aib_link_init_seq.sv
// Bench for aib_link_init_seq: AVMM slave model that echoes writes, with
// controllable stalls, a corrupted readback address and dropped rdatavld.
// Expected AVMM transactions are queued when a sequence is started and
// popped as the DUT gets each command accepted.
module tb_aib_link_init_seq;

    localparam int NCH = 24;
    localparam int ACT = 2;
    localparam int TO  = 16;
    localparam logic [NCH-1:0] AM = 24'h000003;

    logic            avmm_clk   = 1'b0;
    logic            avmm_rst_n = 1'b0;
    logic            start      = 1'b0;
    logic [16:0]     addr;
    logic [3:0]      be;
    logic            rd, wr;
    logic [31:0]     wdata;
    logic [31:0]     rdata   = '0;
    logic            rvld    = 1'b0;
    logic            waitreq = 1'b0;
    logic [NCH-1:0]  adp_rstn, mac_rdy;
    logic [NCH-1:0]  fs_rdy = '0;
    logic [NCH-1:0]  align  = '0;
    logic            link_up, busy, error;
    logic [1:0]      err_code;

    always #5 avmm_clk = ~avmm_clk;

    aib_link_init_seq #(
        .ACTIVE_CHNLS (ACT),
        .NBR_CHNLS    (NCH),
        .AVMM_WIDTH   (32),
        .BYTE_WIDTH   (4),
        .NUM_CFG      (8),
        .TIMEOUT_CYC  (TO)
    ) dut (
        .avmm_clk            (avmm_clk),
        .avmm_rst_n          (avmm_rst_n),
        .start               (start),
        .o_cfg_avmm_addr     (addr),
        .o_cfg_avmm_byte_en  (be),
        .o_cfg_avmm_read     (rd),
        .o_cfg_avmm_write    (wr),
        .o_cfg_avmm_wdata    (wdata),
        .i_cfg_avmm_rdata    (rdata),
        .i_cfg_avmm_rdatavld (rvld),
        .i_cfg_avmm_waitreq  (waitreq),
        .ns_adapter_rstn     (adp_rstn),
        .ns_mac_rdy          (mac_rdy),
        .fs_mac_rdy          (fs_rdy),
        .m_rx_align_done     (align),
        .link_up             (link_up),
        .busy                (busy),
        .error               (error),
        .err_code            (err_code)
    );

    logic [16:0] T_ADDR [8] = '{17'h00208, 17'h0020C, 17'h00210, 17'h00214,
                                17'h00300, 17'h00304, 17'h0031C, 17'h00320};
    logic [31:0] T_DATA [8] = '{32'h0000_0001, 32'h0000_00A5, 32'h8000_0003, 32'h0001_0F00,
                                32'h1234_5678, 32'h0000_0040, 32'h0A0B_0C0D, 32'h0000_0007};

    typedef struct packed {
        logic        wr;
        logic [16:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // AVMM slave model, evaluated on the falling edge
    logic [31:0] mem [logic [16:0]];
    logic        rd_pend    = 1'b0;
    logic [31:0] rd_q       = '0;
    int          stall_left = 0;
    int          wr0_cnt    = 0;
    logic        stall_seen = 1'b0;
    logic        drop_rvld  = 1'b0;
    logic [16:0] bad_addr   = 17'h1FFFF;
    logic [16:0] hold_addr;
    logic [31:0] hold_data;

    always @(negedge avmm_clk) begin : model
        txn_t e;
        if (!avmm_rst_n) begin
            rd_pend    = 1'b0;
            rvld       = 1'b0;
            waitreq    = 1'b0;
            stall_seen = 1'b0;
        end else begin
            rvld    = rd_pend && !drop_rvld;
            rdata   = rd_q;
            rd_pend = 1'b0;
            if (stall_seen && !wr) begin
                chk("stall_wr_held", 64'(wr), 64'd1);
                stall_seen = 1'b0;
            end
            if (wr && stall_left > 0) begin
                if (stall_seen) begin
                    chk("stall_addr", 64'(addr), 64'(hold_addr));
                    chk("stall_wdata", 64'(wdata), 64'(hold_data));
                end
                hold_addr  = addr;
                hold_data  = wdata;
                stall_seen = 1'b1;
                waitreq    = 1'b1;
                stall_left--;
            end else begin
                if (wr && stall_seen) begin
                    chk("stall_addr", 64'(addr), 64'(hold_addr));
                    chk("stall_wdata", 64'(wdata), 64'(hold_data));
                    stall_seen = 1'b0;
                end
                waitreq = 1'b0;
            end
            if ((wr || rd) && !waitreq) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected", 64'({wr, rd, addr}), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk(wr ? "sb_write" : "sb_read", 64'({wr, addr, (wr ? wdata : 32'h0)}), 64'(e));
                end
                if (wr) begin
                    mem[addr] = wdata;
                    chk("byte_en", 64'(be), 64'hF);
                    if (addr == 17'h00208) wr0_cnt++;
                end else begin
                    rd_pend = 1'b1;
                    rd_q    = (addr == bad_addr) ? 32'h0 :
                              (mem.exists(addr) ? mem[addr] : 32'h0);
                end
            end
        end
    end

    task automatic pulse_start();
        @(posedge avmm_clk); #1 start = 1'b1;
        @(posedge avmm_clk); #1 start = 1'b0;
    endtask

    task automatic push_seq(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({1'b1, T_ADDR[i], T_DATA[i]});
            exp_q.push_back({1'b0, T_ADDR[i], 32'h0});
        end
    endtask

    // Returns sampled in the MAC_RDY cycle (first cycle ns_mac_rdy is high).
    task automatic wait_mac(input string tag);
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge avmm_clk); #1;
            if (mac_rdy[0]) ok = 1;
        end
        chk(tag, 64'(ok), 64'd1);
    endtask

    task automatic wait_err(input string tag);
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge avmm_clk); #1;
            if (error) ok = 1;
        end
        chk(tag, 64'(ok), 64'd1);
    endtask

    task automatic wait_rd_accept(input string tag);
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge avmm_clk); #1;
            if (rd && !waitreq) ok = 1;
        end
        chk(tag, 64'(ok), 64'd1);
    endtask

    initial begin
        int spurious;
        // reset state
        repeat (3) @(posedge avmm_clk);
        #1;
        chk("rst_cmd", 64'({rd, wr}), 64'd0);
        chk("rst_addr", 64'(addr), 64'd0);
        chk("rst_rstn", 64'(adp_rstn), 64'd0);
        chk("rst_macrdy", 64'(mac_rdy), 64'd0);
        chk("rst_status", 64'({link_up, busy, error, err_code}), 64'd0);
        #2 avmm_rst_n = 1'b1;

        // full bring-up with entry 0 write stalled 5 cycles
        stall_left = 5;
        push_seq(8);
        pulse_start();
        chk("busy_wr", 64'(busy), 64'd1);
        wait_mac("reach_mac_rdy");
        chk("sb_drain_full", 64'(exp_q.size()), 64'd0);
        chk("wr0_once", 64'(wr0_cnt), 64'd1);
        chk("stall_consumed", 64'(stall_left), 64'd0);
        chk("adp_rstn_act", 64'(adp_rstn), 64'(AM));
        chk("mac_rdy_act", 64'(mac_rdy), 64'(AM));
        @(posedge avmm_clk);
        repeat (3) @(posedge avmm_clk);
        #1 fs_rdy = AM; align = AM;
        chk("link_up_early", 64'(link_up), 64'd0);
        @(posedge avmm_clk); #1;
        chk("link_up", 64'(link_up), 64'd1);
        chk("lu_err_busy", 64'({error, busy}), 64'd0);
        chk("lu_rstn_hi0", 64'(adp_rstn), 64'(AM));

        // drop align on channel 0 while up
        align[0] = 1'b0;
        @(posedge avmm_clk); #1;
        chk("drop_error", 64'(error), 64'd1);
        chk("drop_code", 64'(err_code), 64'd3);
        chk("drop_link", 64'(link_up), 64'd0);
        chk("drop_rstn", 64'({adp_rstn, mac_rdy}), 64'd0);

        // readback mismatch on entry 3
        fs_rdy = '0; align = '0;
        bad_addr = 17'h00214;
        push_seq(4);
        pulse_start();
        wait_err("mism_error");
        chk("mism_code", 64'(err_code), 64'd1);
        chk("mism_rstn", 64'(adp_rstn), 64'd0);
        chk("mism_drain", 64'(exp_q.size()), 64'd0);
        bad_addr = 17'h1FFFF;

        // rdatavld never returned: ERROR exactly TO cycles after RD_WAIT entry
        drop_rvld = 1'b1;
        push_seq(1);
        pulse_start();
        chk("restart_clr", 64'({error, err_code}), 64'd0);
        wait_rd_accept("rd0_accept");
        @(posedge avmm_clk);
        repeat (TO - 1) @(posedge avmm_clk);
        #1 chk("rdto_early", 64'(error), 64'd0);
        @(posedge avmm_clk); #1;
        chk("rdto_error", 64'(error), 64'd1);
        chk("rdto_code", 64'(err_code), 64'd2);
        chk("rdto_drain", 64'(exp_q.size()), 64'd0);
        drop_rvld = 1'b0;

        // align arrives on the very cycle the timeout expires: completion wins
        push_seq(8);
        pulse_start();
        wait_mac("reach_mac_rdy2");
        @(posedge avmm_clk);
        repeat (TO - 1) @(posedge avmm_clk);
        #1 fs_rdy = AM; align = AM;
        @(posedge avmm_clk); #1;
        chk("edge_link_up", 64'({link_up, error}), 64'b10);
        fs_rdy[1] = 1'b0;
        @(posedge avmm_clk); #1;
        chk("fs_drop_code", 64'({error, err_code}), 64'b111);

        // align never arrives: err_code 11 after TO cycles in WAIT_ALIGN
        fs_rdy = '0; align = '0;
        push_seq(8);
        pulse_start();
        wait_mac("reach_mac_rdy3");
        @(posedge avmm_clk);
        repeat (TO - 1) @(posedge avmm_clk);
        #1 chk("alto_early", 64'(error), 64'd0);
        @(posedge avmm_clk); #1;
        chk("alto_error", 64'({error, err_code}), 64'b111);

        // reset pulsed during RD
        push_seq(8);
        pulse_start();
        wait_rd_accept("rd_before_rst");
        #2 avmm_rst_n = 1'b0;
        #1;
        chk("arst_cmd", 64'({rd, wr}), 64'd0);
        chk("arst_addr", 64'(addr), 64'd0);
        chk("arst_status", 64'({busy, error, link_up, err_code}), 64'd0);
        exp_q.delete();
        @(posedge avmm_clk);
        @(posedge avmm_clk);
        #3 avmm_rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge avmm_clk); #1;
            if (rd || wr || busy) spurious++;
        end
        chk("post_rst_idle", 64'(spurious), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
